// File: rtl/logic_writeback_if.sv
`default_nettype none
// ============================================================================
// Module  : logic_writeback_if
// Brief   : Result handshake, load port, operand reads and status of the
//           logic-unit writeback stage.
// Revision: 1.0
// ============================================================================
interface logic_writeback_if #(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_func;
  logic [1:0]    in_op;
  logic [AW-1:0] in_dst;
  logic          ld_valid;
  logic [AW-1:0] ld_dst;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] rd_a_addr;
  logic [AW-1:0] rd_b_addr;
  logic [DW-1:0] rd_a_data;
  logic [DW-1:0] rd_b_data;
  logic          flag_z;
  logic          flag_n;
  logic          flag_p;
  logic [1:0]    last_op;
  logic [15:0]   wb_count;

  modport slave (
    input  in_valid, in_func, in_op, in_dst,
    input  ld_valid, ld_dst, ld_data,
    input  rd_a_addr, rd_b_addr,
    output in_ready, rd_a_data, rd_b_data,
    output flag_z, flag_n, flag_p, last_op, wb_count
  );

  modport master (
    output in_valid, in_func, in_op, in_dst,
    output ld_valid, ld_dst, ld_data,
    output rd_a_addr, rd_b_addr,
    input  in_ready, rd_a_data, rd_b_data,
    input  flag_z, flag_n, flag_p, last_op, wb_count
  );
endinterface
`default_nettype wire

// File: rtl/logic_writeback.sv
`default_nettype none
// ============================================================================
// Module  : logic_writeback
// Brief   : One-entry result stage retiring into a 4x8 register file with
//           Z/N/P flags, bypassed operand reads and a priority load port.
// Revision: 1.0
// ============================================================================
module logic_writeback #(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  logic_writeback_if.slave  bus
);
  localparam int c_AW = $clog2(NREG);
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  logic            r_s_valid;
  logic [DW-1:0]   r_s_func;
  logic [1:0]      r_s_op;
  logic [c_AW-1:0] r_s_dst;
  logic [DW-1:0]   r_regs [NREG];
  logic            r_flag_z;
  logic            r_flag_n;
  logic            r_flag_p;
  logic [1:0]      r_last_op;
  logic [15:0]     r_wb_count;

  logic w_retire;
  logic w_accept;
  logic w_ready;

  // A load owns the write port, so the pending result waits behind it.
  assign w_retire = r_s_valid && !bus.ld_valid;
  assign w_ready  = !r_s_valid || w_retire;
  assign w_accept = bus.in_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_valid  <= 1'b0;
      r_s_func   <= '0;
      r_s_op     <= 2'd0;
      r_s_dst    <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_flag_z   <= 1'b1;
      r_flag_n   <= 1'b0;
      r_flag_p   <= 1'b1;
      r_last_op  <= 2'd0;
      r_wb_count <= 16'd0;
    end else begin
      if (w_accept) begin
        r_s_valid <= 1'b1;
        r_s_func  <= bus.in_func;
        r_s_op    <= bus.in_op;
        r_s_dst   <= bus.in_dst;
      end else if (w_retire) begin
        r_s_valid <= 1'b0;
      end

      if (bus.ld_valid) begin
        r_regs[bus.ld_dst] <= bus.ld_data;
      end else if (w_retire) begin
        r_regs[r_s_dst] <= r_s_func;
        r_flag_z        <= (r_s_func == '0);
        r_flag_n        <= r_s_func[DW-1];
        r_flag_p        <= ~^r_s_func;
        r_last_op       <= r_s_op;
        if (r_wb_count != c_CNT_MAX) r_wb_count <= r_wb_count + 16'd1;
      end
    end
  end

  // The stalled result is younger than any load, so it wins the bypass.
  always_comb begin
    bus.rd_a_data = r_regs[bus.rd_a_addr];
    bus.rd_b_data = r_regs[bus.rd_b_addr];
    if (r_s_valid && (bus.rd_a_addr == r_s_dst)) bus.rd_a_data = r_s_func;
    if (r_s_valid && (bus.rd_b_addr == r_s_dst)) bus.rd_b_data = r_s_func;
  end

  assign bus.in_ready = w_ready;
  assign bus.flag_z   = r_flag_z;
  assign bus.flag_n   = r_flag_n;
  assign bus.flag_p   = r_flag_p;
  assign bus.last_op  = r_last_op;
  assign bus.wb_count = r_wb_count;
endmodule
`default_nettype wire

// File: tb/tb_logic_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_logic_writeback
// Brief   : Directed self-checking bench for logic_writeback.
// Revision: 1.0
// ============================================================================
module tb_logic_writeback;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic_writeback_if #(.DW(8), .AW(2)) bus ();

  logic_writeback #(.DW(8), .NREG(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic z, input logic n, input logic p);
    check_val(tag, {29'd0, bus.flag_z, bus.flag_n, bus.flag_p}, {29'd0, z, n, p});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_func   = 8'h00;
    bus.in_op     = 2'd0;
    bus.in_dst    = 2'd0;
    bus.ld_valid  = 1'b0;
    bus.ld_dst    = 2'd0;
    bus.ld_data   = 8'h00;
    bus.rd_a_addr = 2'd0;
    bus.rd_b_addr = 2'd0;
    step();
    rst = 1'b0;
    #1;

    // reset state
    check_val("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check_flags("rst_flags", 1'b1, 1'b0, 1'b1);
    check_val("rst_lastop", {30'd0, bus.last_op}, 32'd0);
    check_val("rst_count", {16'd0, bus.wb_count}, 32'd0);

    // single result with bypass
    bus.in_valid = 1'b1; bus.in_func = 8'h80; bus.in_op = 2'd2; bus.in_dst = 2'd1;
    bus.rd_a_addr = 2'd1;
    step();
    bus.in_valid = 1'b0;
    #1;
    check_val("single_bypass", {24'd0, bus.rd_a_data}, 32'h80);
    check_val("single_cnt0", {16'd0, bus.wb_count}, 32'd0);
    step();
    check_val("single_reg", {24'd0, bus.rd_a_data}, 32'h80);
    check_flags("single_flags", 1'b0, 1'b1, 1'b0);
    check_val("single_lastop", {30'd0, bus.last_op}, 32'd2);
    check_val("single_cnt", {16'd0, bus.wb_count}, 32'd1);

    // back-to-back
    bus.in_valid = 1'b1; bus.in_func = 8'h00; bus.in_op = 2'd0; bus.in_dst = 2'd0;
    step();
    check_val("b2b_ready1", {31'd0, bus.in_ready}, 32'd1);
    bus.in_func = 8'h03; bus.in_op = 2'd1; bus.in_dst = 2'd2;
    step();
    check_flags("b2b_flags1", 1'b1, 1'b0, 1'b1);
    check_val("b2b_ready2", {31'd0, bus.in_ready}, 32'd1);
    bus.in_func = 8'hFF; bus.in_op = 2'd3; bus.in_dst = 2'd3;
    step();
    check_flags("b2b_flags2", 1'b0, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    step();
    check_flags("b2b_flags3", 1'b0, 1'b1, 1'b1);
    check_val("b2b_lastop", {30'd0, bus.last_op}, 32'd3);
    check_val("b2b_cnt", {16'd0, bus.wb_count}, 32'd4);
    bus.rd_a_addr = 2'd2; bus.rd_b_addr = 2'd3;
    #1;
    check_val("b2b_r2", {24'd0, bus.rd_a_data}, 32'h03);
    check_val("b2b_r3", {24'd0, bus.rd_b_data}, 32'hFF);

    // load stalls a pending result to the same register
    bus.in_valid = 1'b1; bus.in_func = 8'h55; bus.in_op = 2'd1; bus.in_dst = 2'd2;
    step();
    bus.in_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_dst = 2'd2; bus.ld_data = 8'hAA;
    #1;
    check_val("ld_ready1", {31'd0, bus.in_ready}, 32'd0);
    check_val("ld_rd1", {24'd0, bus.rd_a_data}, 32'h55);
    step();
    check_val("ld_ready2", {31'd0, bus.in_ready}, 32'd0);
    check_val("ld_rd2", {24'd0, bus.rd_a_data}, 32'h55);
    check_flags("ld_flags", 1'b0, 1'b1, 1'b1);
    check_val("ld_cnt_hold", {16'd0, bus.wb_count}, 32'd4);
    step();
    bus.ld_valid = 1'b0;
    #1;
    check_val("ld_ready3", {31'd0, bus.in_ready}, 32'd1);
    step();
    check_val("ld_reg", {24'd0, bus.rd_a_data}, 32'h55);
    check_val("ld_cnt", {16'd0, bus.wb_count}, 32'd5);
    check_flags("ld_flags_ret", 1'b0, 1'b0, 1'b1);
    check_val("ld_lastop", {30'd0, bus.last_op}, 32'd1);

    // load without a pending result
    bus.ld_valid = 1'b1; bus.ld_dst = 2'd3; bus.ld_data = 8'h0F;
    #1;
    check_val("ldo_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.ld_valid = 1'b0;
    #1;
    check_val("ldo_r3", {24'd0, bus.rd_b_data}, 32'h0F);
    check_val("ldo_cnt", {16'd0, bus.wb_count}, 32'd5);
    check_flags("ldo_flags", 1'b0, 1'b0, 1'b1);

    // reset while a result is pending
    bus.in_valid = 1'b1; bus.in_func = 8'h12; bus.in_op = 2'd0; bus.in_dst = 2'd1;
    bus.rd_a_addr = 2'd1;
    step();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_val("mrst_r1", {24'd0, bus.rd_a_data}, 32'h00);
    check_val("mrst_r3", {24'd0, bus.rd_b_data}, 32'h00);
    check_val("mrst_cnt", {16'd0, bus.wb_count}, 32'd0);
    check_flags("mrst_flags", 1'b1, 1'b0, 1'b1);
    check_val("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    check_val("mrst_noret", {16'd0, bus.wb_count}, 32'd0);
    check_val("mrst_r1b", {24'd0, bus.rd_a_data}, 32'h00);

    // saturation: N edges with in_valid held give N-1 retires
    bus.in_valid = 1'b1; bus.in_func = 8'h01; bus.in_op = 2'd0; bus.in_dst = 2'd0;
    repeat (65535) @(posedge clk);
    #1;
    check_val("sat_fffe", {16'd0, bus.wb_count}, 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check_val("sat_ffff", {16'd0, bus.wb_count}, 32'hFFFF);
    bus.in_valid = 1'b0;
    step();
    check_val("sat_hold", {16'd0, bus.wb_count}, 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
